// File: rtl/axi_spi_sd_host.sv
// Single-outstanding AXI-Lite master: turns one host register command into an
// AXI-Lite read or write, with a per-transaction bus-stall timeout.
//
// state   | meaning
// IDLE    | CMD_READY high, waiting for a host command
// WR_AW_W | AWVALID/WVALID offered, each drops after its own handshake
// WR_B    | BREADY high, waiting for the write response
// RD_AR   | ARVALID offered, waiting for ARREADY
// RD_R    | RREADY high, waiting for read data
// RSP     | result presented on RSP_*, waiting for RSP_READY
module axi_spi_sd_host #(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_TIMEOUT_CYCLES   = 256
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic                          CMD_VALID,
   output logic                          CMD_READY,
   input  logic                          CMD_WRITE,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] CMD_ADDR,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] CMD_WDATA,
   output logic                          RSP_VALID,
   input  logic                          RSP_READY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] RSP_RDATA,
   output logic [1:0]                    RSP_RESP,
   output logic                          RSP_TIMEOUT,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(C_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

   state_t                          state_q;
   logic                            cmd_ready_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
   logic [CW-1:0]                   cnt_q;
   logic                            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic                            rsp_valid_q, rsp_timeout_q;
   logic [1:0]                      rsp_resp_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;

   logic aw_ok, w_ok, busy, advance, abort;

   // A channel counts as done if it already handshook or is handshaking now.
   assign aw_ok = !awvalid_q || M_AXI_AWREADY;
   assign w_ok  = !wvalid_q  || M_AXI_WREADY;
   assign busy  = (state_q == WR_AW_W) || (state_q == WR_B) ||
                  (state_q == RD_AR)   || (state_q == RD_R);

   always_comb begin
      advance = 1'b0;
      case (state_q)
         WR_AW_W: advance = aw_ok && w_ok;
         WR_B:    advance = M_AXI_BVALID;
         RD_AR:   advance = M_AXI_ARREADY;
         RD_R:    advance = M_AXI_RVALID;
         default: advance = 1'b0;
      endcase
   end

   // A completing handshake on the final counted cycle wins over the timeout.
   assign abort = busy && (cnt_q == TMO_LAST) && !advance;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cnt_q         <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_resp_q    <= 2'b00;
         rsp_rdata_q   <= '0;
      end else begin
         if (busy) cnt_q <= cnt_q + CW'(1);
         if (abort) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_resp_q    <= 2'b10;
            rsp_rdata_q   <= '0;
            state_q       <= RSP;
         end else begin
            case (state_q)
               IDLE: begin
                  cmd_ready_q <= 1'b1;
                  if (CMD_VALID && cmd_ready_q) begin
                     cmd_ready_q <= 1'b0;
                     addr_q      <= CMD_ADDR;
                     wdata_q     <= CMD_WDATA;
                     cnt_q       <= '0;
                     if (CMD_WRITE) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= WR_AW_W;
                     end else begin
                        arvalid_q <= 1'b1;
                        state_q   <= RD_AR;
                     end
                  end
               end
               WR_AW_W: begin
                  if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
                  if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
                  if (advance) begin
                     bready_q <= 1'b1;
                     state_q  <= WR_B;
                  end
               end
               WR_B: begin
                  if (advance) begin
                     bready_q      <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     rsp_timeout_q <= 1'b0;
                     rsp_resp_q    <= M_AXI_BRESP;
                     rsp_rdata_q   <= '0;
                     state_q       <= RSP;
                  end
               end
               RD_AR: begin
                  if (advance) begin
                     arvalid_q <= 1'b0;
                     rready_q  <= 1'b1;
                     state_q   <= RD_R;
                  end
               end
               RD_R: begin
                  if (advance) begin
                     rready_q      <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     rsp_timeout_q <= 1'b0;
                     rsp_resp_q    <= M_AXI_RRESP;
                     rsp_rdata_q   <= M_AXI_RDATA;
                     state_q       <= RSP;
                  end
               end
               RSP: begin
                  if (RSP_READY) begin
                     rsp_valid_q <= 1'b0;
                     cmd_ready_q <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign CMD_READY     = cmd_ready_q;
   assign RSP_VALID     = rsp_valid_q;
   assign RSP_RDATA     = rsp_rdata_q;
   assign RSP_RESP      = rsp_resp_q;
   assign RSP_TIMEOUT   = rsp_timeout_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_spi_sd_host.sv
// Scoreboard bench for axi_spi_sd_host: a configurable AXI-Lite slave with a
// register array, a reference register map and a decoupled response monitor.
module tb_axi_spi_sd_host;
   localparam int TMO = 256;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
   logic [31:0] wdata, rdata = '0;
   logic [3:0]  wstrb;
   logic [1:0]  bresp = '0, rresp = '0;
   logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

   axi_spi_sd_host dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
      .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
      .RSP_RESP(rsp_resp), .RSP_TIMEOUT(rsp_timeout),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic        to;
      logic [1:0]  resp;
      logic [31:0] rdata;
      bit          lat_chk;
      int          lat;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0, errors = 0;
   int cyc = 0, acc_cyc = 0, rise_cyc = 0;
   int n_acc = 0, n_rsp = 0, n_arhs = 0, n_bready_rise = 0;
   bit rsp_seen = 0, saw_w_only = 0, rr_force_low = 0;

   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];
   bit          got_aw = 0, got_w = 0, got_ar = 0;
   logic [3:0]  wr_addr = '0, rd_addr = '0;
   logic [31:0] wr_data = '0;
   int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
   bit          cfg_no_aw = 0;
   logic [1:0]  cfg_resp = 2'b00;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slave: record handshakes at the active edge.
   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         got_aw = 0; got_w = 0; got_ar = 0;
      end else begin
         if (awvalid && awready) begin got_aw = 1; wr_addr = awaddr; chk("awprot", 64'(awprot), 64'(0)); end
         if (wvalid && wready)   begin got_w = 1;  wr_data = wdata;  chk("wstrb", 64'(wstrb), 64'hF); end
         if (bvalid && bready)   begin got_aw = 0; got_w = 0; slv_mem[wr_addr] = wr_data; end
         if (arvalid && arready) begin got_ar = 1; rd_addr = araddr; n_arhs++; chk("arprot", 64'(arprot), 64'(0)); end
         if (rvalid && rready)   got_ar = 0;
      end
   end

   // Slave: drive ready/valid mid-cycle with configured wait states.
   initial begin
      int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
         end else begin
            awready = awvalid && !cfg_no_aw && (aw_w >= cfg_aw_dly);
            aw_w    = awvalid ? aw_w + 1 : 0;
            wready  = wvalid && (w_w >= cfg_w_dly);
            w_w     = wvalid ? w_w + 1 : 0;
            bvalid  = got_aw && got_w && (b_w >= cfg_b_dly);
            b_w     = (got_aw && got_w) ? b_w + 1 : 0;
            bresp   = cfg_resp;
            arready = arvalid && (ar_w >= cfg_ar_dly);
            ar_w    = arvalid ? ar_w + 1 : 0;
            rvalid  = got_ar && (r_w >= cfg_r_dly);
            r_w     = got_ar ? r_w + 1 : 0;
            rdata   = got_ar ? slv_mem[rd_addr] : 32'h0;
            rresp   = cfg_resp;
         end
      end
   end

   initial forever begin
      @(negedge clk); #1;
      rsp_ready = rr_force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Monitor: protocol stability and scoreboard comparison.
   initial begin
      logic [31:0] h_rdata, h_wdata;
      logic [1:0]  h_resp;
      logic        h_to;
      logic [3:0]  h_awaddr, h_araddr;
      bit          h_rsp = 0, h_aw = 0, h_w = 0, h_ar = 0;
      logic        prev_bready = 0;
      exp_t        e;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            rsp_seen = 0; h_rsp = 0; h_aw = 0; h_w = 0; h_ar = 0; prev_bready = 0;
         end else begin
            if (cmd_valid && cmd_ready) begin acc_cyc = cyc; n_acc++; end
            if (bready && !prev_bready) n_bready_rise++;
            prev_bready = bready;
            if (awvalid && !wvalid) saw_w_only = 1;
            if (h_aw && awvalid) chk("awaddr_stable", 64'(awaddr), 64'(h_awaddr));
            if (h_w && wvalid)   chk("wdata_stable", 64'(wdata), 64'(h_wdata));
            if (h_ar && arvalid) chk("araddr_stable", 64'(araddr), 64'(h_araddr));
            h_aw = awvalid && !awready; h_awaddr = awaddr;
            h_w  = wvalid && !wready;   h_wdata  = wdata;
            h_ar = arvalid && !arready; h_araddr = araddr;
            if (rsp_valid && !rsp_seen) begin
               rsp_seen = 1; rise_cyc = cyc;
               chk("axi_quiet_in_rsp", 64'({awvalid, wvalid, bready, arvalid, rready, cmd_ready}), 64'(0));
            end
            if (h_rsp && rsp_valid) begin
               chk("rsp_rdata_stable", 64'(rsp_rdata), 64'(h_rdata));
               chk("rsp_resp_stable", 64'(rsp_resp), 64'(h_resp));
               chk("rsp_timeout_stable", 64'(rsp_timeout), 64'(h_to));
            end
            h_rsp = rsp_valid && !rsp_ready;
            h_rdata = rsp_rdata; h_resp = rsp_resp; h_to = rsp_timeout;
            if (rsp_valid && rsp_ready) begin
               n_rsp++; rsp_seen = 0;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_rsp: got resp %0h data %0h, required none", rsp_resp, rsp_rdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                  chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                  chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                  if (e.lat_chk) chk("rsp_latency", 64'(rise_cyc - acc_cyc), 64'(e.lat));
               end
            end
         end
      end
   end

   task automatic do_cmd(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input bit lat_chk, input int lat, input bit to);
      exp_t e;
      bit   ok = 0;
      e.to = to; e.lat_chk = lat_chk; e.lat = lat;
      if (to) begin e.resp = 2'b10; e.rdata = '0; end
      else if (wr) begin e.resp = cfg_resp; e.rdata = '0; ref_mem[a] = d; end
      else begin e.resp = cfg_resp; e.rdata = ref_mem[a]; end
      exp_q.push_back(e);
      @(negedge clk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      for (int i = 0; i < 1000; i++) begin
         if (cmd_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin checks++; errors++; $display("FAIL cmd_accept: CMD_READY never seen, required 1"); end
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000; i++) begin
         if (exp_q.size() == 0 && !rsp_valid) break;
         @(negedge clk);
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      rst_n = 0;
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_axi_out", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
      chk("rst_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'(0));
      chk("rst_rdata", 64'(rsp_rdata), 64'(0));
      exp_q.delete();
      cmd_valid = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      #1 chk("rel_cmd_ready_pre", 64'(cmd_ready), 64'(0));
      @(posedge clk); #1;
      chk("rel_cmd_ready_post", 64'(cmd_ready), 64'(1));
   endtask

   task automatic zero_cfg();
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
      cfg_no_aw = 0; cfg_resp = 2'b00;
   endtask

   initial begin
      int b0, r0, a0, ar0;
      logic [31:0] d;
      for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
      do_reset();

      // zero-wait write, then write with W finishing well before AW
      zero_cfg();
      do_cmd(1, 4'h1, 32'hFFFF_FFFF, 1, 3, 0);
      wait_idle();
      cfg_aw_dly = 3;
      saw_w_only = 0; b0 = n_bready_rise; r0 = n_rsp;
      do_cmd(1, 4'h0, 32'h0000_0002, 0, 0, 0);
      wait_idle();
      chk("w_before_aw_seen", 64'(saw_w_only), 64'(1));
      chk("one_bready_phase", 64'(n_bready_rise - b0), 64'(1));
      chk("one_response", 64'(n_rsp - r0), 64'(1));

      // delayed ARREADY read, then zero-wait read latency
      zero_cfg(); cfg_ar_dly = 2;
      do_cmd(0, 4'h0, 32'h0, 0, 0, 0);
      wait_idle();
      zero_cfg();
      do_cmd(0, 4'h1, 32'h0, 1, 3, 0);
      wait_idle();

      // randomized traffic against the reference register map
      for (int n = 0; n < 40; n++) begin
         cfg_aw_dly = $urandom_range(0, 5); cfg_w_dly = $urandom_range(0, 5);
         cfg_b_dly  = $urandom_range(0, 5); cfg_ar_dly = $urandom_range(0, 5);
         cfg_r_dly  = $urandom_range(0, 5); cfg_resp = 2'($urandom_range(0, 3));
         d = $urandom;
         do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d, 0, 0, 0);
         wait_idle();
      end

      // response held off: outputs frozen, extra commands ignored
      zero_cfg();
      rr_force_low = 1;
      do_cmd(1, 4'h7, 32'hA5A5_0F0F, 1, 3, 0);
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) break;
         @(negedge clk);
      end
      chk("stall_rsp_valid", 64'(rsp_valid), 64'(1));
      a0 = n_acc; ar0 = n_arhs;
      repeat (5) begin
         @(negedge clk);
         chk("stall_cmd_ready", 64'(cmd_ready), 64'(0));
         chk("stall_rsp_held", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'(4'b1000));
         cmd_valid = 1; cmd_write = 0; cmd_addr = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      cmd_valid = 0;
      rr_force_low = 0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("stall_no_accept", 64'(n_acc - a0), 64'(0));
      chk("stall_no_read", 64'(n_arhs - ar0), 64'(0));

      // RVALID on the last counted cycle completes normally
      zero_cfg(); cfg_r_dly = TMO - 2;
      do_cmd(0, 4'h7, 32'h0, 1, TMO + 1, 0);
      wait_idle();
      // one cycle later the timeout wins
      cfg_r_dly = TMO - 1;
      do_cmd(0, 4'h7, 32'h0, 1, TMO + 1, 1);
      wait_idle();
      do_reset();

      // slave never accepts the write address
      zero_cfg(); cfg_no_aw = 1;
      do_cmd(1, 4'h3, 32'h1234_5678, 1, TMO + 1, 1);
      wait_idle();
      chk("tmo_valids_low", 64'({awvalid, wvalid}), 64'(0));
      do_reset();

      // reset in the middle of a read address phase
      zero_cfg(); cfg_ar_dly = 1000;
      do_cmd(0, 4'h2, 32'h0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (arvalid) break;
         @(negedge clk);
      end
      chk("arvalid_before_rst", 64'(arvalid), 64'(1));
      do_reset();

      // post-reset sanity read of a previously written register
      zero_cfg();
      do_cmd(0, 4'h7, 32'h0, 1, 3, 0);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
